// File: rtl/alert_receiver_array.sv
// alert_receiver_array: NumAlerts differential alert receivers with ack handshake,
// ping issue/timeout tracking and sticky cause capture.
module alert_receiver_array #(
  parameter int unsigned NumAlerts = 4,
  parameter int unsigned TimeoutW  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumAlerts-1:0]   ping_en_i,
  input  logic [TimeoutW-1:0]    ping_timeout_cyc_i,
  input  logic [NumAlerts-1:0]   cause_clr_i,
  input  logic [2*NumAlerts-1:0] alert_tx_i,
  output logic [4*NumAlerts-1:0] alert_rx_o,
  output logic [NumAlerts-1:0]   alert_o,
  output logic [NumAlerts-1:0]   ping_ok_o,
  output logic [NumAlerts-1:0]   ping_timeout_o,
  output logic [NumAlerts-1:0]   integ_fail_o,
  output logic [NumAlerts-1:0]   cause_o
);
  typedef enum logic [1:0] {Idle, HsAckWait, Pause0, Pause1} state_e;
  for (genvar k = 0; k < NumAlerts; k++) begin : g_ch
    state_e state_q, state_d;
    logic ack_q, ack_d, tog_q, en_q, pend_q, pend_d, cause_q;
    logic sigint, level, rise, alert, ok, tmo;
    logic [TimeoutW-1:0] cnt_q, cnt_d;
    assign sigint = alert_tx_i[2*k+1] ~^ alert_tx_i[2*k];
    assign level  = alert_tx_i[2*k+1] & ~sigint;
    assign rise   = ping_en_i[k] & ~en_q;
    always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      alert   = 1'b0;
      ok      = 1'b0;
      case (state_q)
        Idle: if (level) begin
          state_d = HsAckWait;
          ack_d   = 1'b1;
          ok      = pend_q;
          alert   = ~pend_q;
        end
        HsAckWait: begin
          ack_d   = level;
          state_d = level ? HsAckWait : Pause0;
        end
        Pause0:  state_d = Pause1;
        default: state_d = Idle;
      endcase
      if (sigint) begin
        state_d = Idle;
        ack_d   = 1'b0;
        alert   = 1'b0;
        ok      = 1'b0;
      end
    end
    // an answer in the expiry cycle counts as a ping_ok, never a timeout
    assign tmo = pend_q & (ping_timeout_cyc_i != '0) &
                 (cnt_q == ping_timeout_cyc_i - TimeoutW'(1)) & ~ok & ~rise;
    assign pend_d = rise | (pend_q & ping_en_i[k] & ~ok & ~tmo);
    assign cnt_d  = rise ? '0 : (pend_q && cnt_q != '1) ? cnt_q + TimeoutW'(1) : cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= Idle;
        ack_q   <= 1'b0;
        tog_q   <= 1'b0;
        en_q    <= 1'b0;
        pend_q  <= 1'b0;
        cnt_q   <= '0;
        cause_q <= 1'b0;
      end else begin
        state_q <= state_d;
        ack_q   <= ack_d;
        tog_q   <= tog_q ^ rise;
        en_q    <= ping_en_i[k];
        pend_q  <= pend_d;
        cnt_q   <= cnt_d;
        cause_q <= (cause_q & ~cause_clr_i[k]) | alert | sigint;
      end
    end
    assign alert_rx_o[4*k+3 -: 4] = {tog_q, ~tog_q, ack_q, ~ack_q};
    assign alert_o[k]        = alert;
    assign ping_ok_o[k]      = ok;
    assign ping_timeout_o[k] = tmo;
    assign integ_fail_o[k]   = sigint;
    assign cause_o[k]        = cause_q;
  end
endmodule

// File: tb/tb_alert_receiver_array.sv
// tb_alert_receiver_array: directed checks of alert, ping, timeout, integrity and reset behaviour.
module tb_alert_receiver_array;
  localparam int N = 4;
  localparam int TW = 16;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [N-1:0] ping_en = '0;
  logic [N-1:0] cause_clr = '0;
  logic [TW-1:0] thr = '0;
  logic [2*N-1:0] tx = 8'h55;
  logic [4*N-1:0] rx;
  logic [N-1:0] alert, ping_ok, ping_tmo, integ, cause;
  int pass_cnt = 0;
  int total = 0;
  int seen;
  always #5 clk = ~clk;
  alert_receiver_array #(.NumAlerts(N), .TimeoutW(TW)) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .ping_en_i(ping_en),
    .ping_timeout_cyc_i(thr),
    .cause_clr_i(cause_clr),
    .alert_tx_i(tx),
    .alert_rx_o(rx),
    .alert_o(alert),
    .ping_ok_o(ping_ok),
    .ping_timeout_o(ping_tmo),
    .integ_fail_o(integ),
    .cause_o(cause)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  initial begin
    #12;
    chk("rst_rx", rx, 16'h5555);
    chk("rst_cause", cause, 0);
    chk("rst_pulses", {alert, ping_ok, ping_tmo, integ}, 0);
    nxt();
    rst_ni = 1'b1;
    nxt();
    // alert on channel 2
    tx[5:4] = 2'b10; mid();
    chk("al_pulse", alert, 4'b0100);
    chk("al_ack_lat", rx[9], 0);
    nxt(); mid();
    chk("al_pulse_once", alert, 0);
    chk("al_ack_b", rx[9], 1);
    chk("al_cause", cause, 4'b0100);
    nxt(); mid();
    chk("al_ack_c", rx[9], 1);
    nxt(); tx[5:4] = 2'b01; mid();
    chk("al_ack_d", rx[9], 1);
    nxt(); tx[5:4] = 2'b10; mid();
    chk("al_pause_ignored", alert, 0);
    chk("al_ack_fall", rx[9:8], 2'b01);
    nxt(); tx[5:4] = 2'b01; cause_clr = 4'b0100;
    nxt(); cause_clr = '0; mid();
    chk("al_cause_clr", cause, 0);
    nxt();
    // ping answered on channel 0
    thr = 16'd20; ping_en[0] = 1'b1; mid();
    chk("po_rx_before", rx[3:2], 2'b01);
    nxt(); mid();
    chk("po_rx_tog", rx[3:2], 2'b10);
    repeat (3) nxt();
    tx[1:0] = 2'b10; mid();
    chk("po_ok", ping_ok, 4'b0001);
    chk("po_no_alert", alert, 0);
    chk("po_no_tmo", ping_tmo, 0);
    nxt(); tx[1:0] = 2'b01; mid();
    chk("po_ok_once", ping_ok, 0);
    repeat (3) nxt();
    // ping timeout on channel 1, threshold 5
    thr = 16'd5; ping_en[1] = 1'b1;
    repeat (4) nxt(); mid();
    chk("pt_early", ping_tmo, 0);
    chk("pt_rx_tog", rx[7:6], 2'b10);
    nxt(); mid();
    chk("pt_fire", ping_tmo, 4'b0010);
    nxt(); mid();
    chk("pt_once", ping_tmo, 0);
    nxt(); tx[3:2] = 2'b10; mid();
    chk("pt_late_alert", alert, 4'b0010);
    chk("pt_late_no_ok", ping_ok, 0);
    nxt(); tx[3:2] = 2'b01;
    repeat (3) nxt();
    // integrity failure on channel 3 during HsAckWait
    tx[7:6] = 2'b10; mid();
    chk("ig_alert", alert, 4'b1000);
    nxt(); mid();
    chk("ig_ack_wait", rx[13], 1);
    nxt(); tx[7:6] = 2'b11; cause_clr[3] = 1'b1; mid();
    chk("ig_fail", integ, 4'b1000);
    chk("ig_no_alert", alert, 0);
    nxt(); tx[7:6] = 2'b01; cause_clr = '0; mid();
    chk("ig_cause_kept", cause[3], 1);
    chk("ig_ack0", rx[13], 0);
    chk("ig_fail_gone", integ, 0);
    nxt(); tx[7:6] = 2'b10; mid();
    chk("ig_back_idle", alert, 4'b1000);
    nxt(); tx[7:6] = 2'b01;
    repeat (3) nxt();
    cause_clr = 4'b1100;
    nxt(); cause_clr = '0; mid();
    chk("ig_cause_clr", cause & 4'b1000, 0);
    // threshold 0 never times out
    thr = '0; ping_en[2] = 1'b1; seen = 0;
    repeat (30) begin nxt(); mid(); if (ping_tmo[2]) seen = 1; end
    chk("t0_none", seen, 0);
    // dropping ping_en cancels silently
    thr = 16'd4; ping_en[3] = 1'b1; nxt(); ping_en[3] = 1'b0; seen = 0;
    repeat (8) begin nxt(); mid(); if (ping_tmo[3]) seen = 1; end
    chk("cancel_no_tmo", seen, 0);
    // answer in the exact timeout cycle
    thr = 16'd3; ping_en[0] = 1'b0; nxt(); ping_en[0] = 1'b1;
    repeat (3) nxt();
    tx[1:0] = 2'b10; mid();
    chk("edge_ok", ping_ok, 4'b0001);
    chk("edge_no_tmo", ping_tmo, 0);
    nxt(); tx[1:0] = 2'b01;
    repeat (3) nxt();
    // asynchronous reset during HsAckWait
    tx[3:2] = 2'b10; nxt(); mid();
    chk("rs_ack_up", rx[5], 1);
    chk("rs_cause_up", cause[1], 1);
    #1; rst_ni = 1'b0; tx = 8'h55; #1;
    chk("rs_rx", rx, 16'h5555);
    chk("rs_pulses", {alert, ping_ok, ping_tmo, integ}, 0);
    chk("rs_cause", cause, 0);
    nxt(); rst_ni = 1'b1; nxt();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/alert_receiver_array.md
# alert_receiver_array

Multi-channel differential alert receiver for the alert handler front end. It terminates `NumAlerts` independent alert sender links. Per channel it decodes the differential alert pair, runs the four-phase ack handshake, and issues ping requests by toggling the ping pair. Beyond a single-channel receiver, it adds a per-channel ping timeout counter, sticky per-channel cause capture with software clear, and packed vector ports.

## Interface
- `NumAlerts`, default 4: number of channels (1..64).
- `TimeoutW`, default 16: width of the ping timeout counter and threshold.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `ping_en_i`  in  NumAlerts  per-channel ping request level; a 0→1 rise issues one ping.
- `ping_timeout_cyc_i`  in  TimeoutW  shared timeout threshold in cycles; 0 disables the timeout.
- `cause_clr_i`  in  NumAlerts  per-channel clear of `cause_o`.
- `alert_tx_i`  in  2*NumAlerts  channel k: `[2k+1]` = alert_p, `[2k]` = alert_n. Synchronous to `clk_i`.
- `alert_rx_o`  out  4*NumAlerts  channel k: `[4k+3]` = ping_p, `[4k+2]` = ping_n, `[4k+1]` = ack_p, `[4k]` = ack_n. Driven directly from flops.
- `alert_o`  out  NumAlerts  one-cycle pulse per genuine alert.
- `ping_ok_o`  out  NumAlerts  one-cycle pulse when a pending ping is answered.
- `ping_timeout_o`  out  NumAlerts  one-cycle pulse when a pending ping expires.
- `integ_fail_o`  out  NumAlerts  high in every cycle the alert pair is non-complementary.
- `cause_o`  out  NumAlerts  sticky: set by `alert_o` or `integ_fail_o`.

## Operation
- Each channel is an independent replica. Channels share only `ping_timeout_cyc_i`.
- Decode (combinational):
  - `sigint = alert_p ~^ alert_n`.
  - `level = alert_p & ~sigint`.
- FSM states and transitions:
  - Idle → HsAckWait on `level`. In that cycle: `ack_d = 1`; pulse `ping_ok_o` if the ping is pending, else pulse `alert_o`.
  - HsAckWait: `ack_d = 1` while `level`; on `!level` → Pause0.
  - Pause0 → Pause1 → Idle, unconditionally. Alerts during the pauses are ignored.
- Integrity override (`sigint`): state_d = Idle, ack_d = 0, `ping_ok_o = alert_o = 0`, `integ_fail_o = 1`.
- Ping:
  - `rise = ping_en_i & ~ping_en_q`.
  - On `rise`, `ping_tog_q` toggles; ping_p = `ping_tog_q`, ping_n = `~ping_tog_q`.
  - `pending_d = rise | (pending_q & ping_en_i & ~ping_ok_o & ~ping_timeout_o)`.
  - Dropping `ping_en_i` cancels a pending ping silently, with no timeout.
- Timeout counter:
  - Cleared on `rise`.
  - Increments (saturating) each cycle while `pending_q`.
  - `ping_timeout_o = pending_q & (ping_timeout_cyc_i != 0) & (cnt_q == ping_timeout_cyc_i - 1) & ~ping_ok_o & ~rise`.
  - `ping_ok_o` wins over a timeout in the same cycle.
  - A new `rise` while pending re-toggles the ping and restarts the count.
- Cause:
  - `cause_d = (cause_q & ~cause_clr_i) | alert_o | integ_fail_o`.
  - Set wins over a same-cycle clear.

## Timing
- Reset values:
  - State Idle; ack_q, ping_tog_q, ping_en_q, pending_q, cnt_q and cause_q all 0.
  - `alert_rx_o` per channel = 4'b0101.
  - All pulse outputs are 0 whenever the inputs are a valid idle pair (p=0, n=1).
- Pulse outputs are combinational from `alert_tx_i` and state, asserted in the cycle the condition is seen.
- Ack latency:
  - ack_p rises 1 cycle after `level` is first seen in Idle.
  - ack_p falls 1 cycle after `level` drops.
- Minimum full-handshake-to-next-accept: 2 cycles after the HsAckWait exit (Pause0, Pause1).
- Ping toggle appears on `alert_rx_o` 1 cycle after `ping_en_i` rises.
- Timeout fires exactly T cycles after the rise cycle for threshold T ≥ 1.
- Reset mid-handshake: all flops clear asynchronously; `alert_rx_o` returns to 0101 immediately.
- Counter saturation at all-ones never wraps; with T ≤ 2^TimeoutW − 1 the timeout always fires first.

## Test plan
- Alert on ch2: drive `alert_tx_i[5:4]` = 10 for 3 cycles, then 01. Expect:
  - `alert_o[2]` 1-cycle pulse;
  - ack_p[2] high for 3 cycles starting 1 cycle later;
  - `cause_o[2]` = 1;
  - other channels unaffected.
- Ping OK on ch0: rise `ping_en_i[0]`, answer with 10 on cycle 4. Expect:
  - `alert_rx_o[3:2]` toggles to 10;
  - `ping_ok_o[0]` pulse;
  - no `alert_o`, no timeout.
- Ping timeout: threshold = 5, ping ch1, no response. Expect:
  - `ping_timeout_o[1]` on cycle 5 after the rise;
  - pending cleared;
  - a later response reports `alert_o[1]`, not `ping_ok_o`.
- Integrity: ch3 pair = 11 mid-HsAckWait. Expect:
  - `integ_fail_o[3]` = 1;
  - state Idle, ack 0;
  - `cause_o[3]` set;
  - `cause_clr_i[3]` in the same cycle does not clear it, a later clear does.
- Boundaries:
  - threshold = 0: no timeout ever;
  - ping response on the exact timeout cycle → `ping_ok_o` only;
  - `rst_ni` low during HsAckWait → outputs 0101 and 0 asynchronously.
